// File: rtl/mem_port_arbiter_if.sv
// Shared-port bundle: CPU fetch and load/store channels plus the memory port.
// slave is the arbiter side; master is the CPU/memory side driving it.
interface mem_port_arbiter_if;
    logic        inst_req_valid;
    logic [31:0] inst_addr;
    logic        inst_req_ready;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_req_ready;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        data_rready;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rready;

    modport slave (
        input  inst_req_valid, inst_addr, inst_ready,
        input  data_read, data_write, data_addr, data_wdata, data_wstrb,
        input  data_rready, mem_req_ready, mem_rdata, mem_rvalid,
        output inst_req_ready, inst_rdata, inst_valid,
        output data_req_ready, data_rdata, data_rvalid,
        output mem_addr, mem_read, mem_write, mem_wdata, mem_wstrb,
        output mem_rready
    );

    modport master (
        output inst_req_valid, inst_addr, inst_ready,
        output data_read, data_write, data_addr, data_wdata, data_wstrb,
        output data_rready, mem_req_ready, mem_rdata, mem_rvalid,
        input  inst_req_ready, inst_rdata, inst_valid,
        input  data_req_ready, data_rdata, data_rvalid,
        input  mem_addr, mem_read, mem_write, mem_wdata, mem_wstrb,
        input  mem_rready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// one transaction outstanding, with grant/contention performance counters.
module mem_port_arbiter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus,
    output logic [CNT_W-1:0] inst_grant_cnt,
    output logic [CNT_W-1:0] data_grant_cnt,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nx;
    logic   grant, grant_nx;
    logic   last, last_nx;
    logic   inc_i, inc_d, inc_c;
    logic   req_rd, req_wr;
    logic   inst_pend, data_pend;

    assign inst_pend = bus.inst_req_valid;
    assign data_pend = bus.data_read | bus.data_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            grant          <= 1'b0;
            last           <= 1'b1;
            inst_grant_cnt <= '0;
            data_grant_cnt <= '0;
            conflict_cnt   <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            last  <= last_nx;
            if (inc_i) inst_grant_cnt <= inst_grant_cnt + ONE;
            if (inc_d) data_grant_cnt <= data_grant_cnt + ONE;
            if (inc_c) conflict_cnt   <= conflict_cnt + ONE;
        end
    end

    always_comb begin
        state_nx           = state;
        grant_nx           = grant;
        last_nx            = last;
        inc_i              = 1'b0;
        inc_d              = 1'b0;
        inc_c              = 1'b0;
        req_rd             = 1'b0;
        req_wr             = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_wdata      = '0;
        bus.mem_wstrb      = '0;
        bus.mem_rready     = 1'b0;
        bus.inst_req_ready = 1'b0;
        bus.data_req_ready = 1'b0;
        bus.inst_valid     = 1'b0;
        bus.data_rvalid    = 1'b0;
        // Read data is pure routing; only the valids are qualified.
        bus.inst_rdata     = bus.mem_rdata;
        bus.data_rdata     = bus.mem_rdata;

        unique case (state)
            IDLE: begin
                if (inst_pend | data_pend) begin
                    if (inst_pend & data_pend) begin
                        grant_nx = ~last;
                        inc_c    = 1'b1;
                    end else begin
                        grant_nx = data_pend;
                    end
                    last_nx  = grant_nx;
                    inc_i    = ~grant_nx;
                    inc_d    = grant_nx;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (grant) begin
                    req_rd             = bus.data_read & ~bus.data_write;
                    req_wr             = bus.data_write;
                    bus.mem_addr       = bus.data_addr;
                    bus.mem_wdata      = bus.data_wdata;
                    bus.mem_wstrb      = bus.data_wstrb;
                    bus.data_req_ready = bus.mem_req_ready;
                end else begin
                    req_rd             = bus.inst_req_valid;
                    bus.mem_addr       = bus.inst_addr;
                    bus.inst_req_ready = bus.mem_req_ready;
                end
                bus.mem_read  = req_rd;
                bus.mem_write = req_wr;
                if (bus.mem_req_ready & (req_rd | req_wr))
                    state_nx = req_wr ? IDLE : RESP;
            end
            RESP: begin
                bus.mem_rready  = grant ? bus.data_rready : bus.inst_ready;
                bus.inst_valid  = ~grant & bus.mem_rvalid;
                bus.data_rvalid = grant & bus.mem_rvalid;
                if (bus.mem_rvalid & bus.mem_rready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction-level bench for mem_port_arbiter with a
// round-robin ownership and counter reference model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    logic [31:0] igc, dgc, cc;

    mem_port_arbiter #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .inst_grant_cnt (igc),
        .data_grant_cnt (dgc),
        .conflict_cnt   (cc)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who won last, and how many grants/conflicts so far.
    bit          prev_data;
    int unsigned m_i, m_d, m_c;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.inst_req_valid = 0;
        bus.inst_addr      = 0;
        bus.inst_ready     = 0;
        bus.data_read      = 0;
        bus.data_write     = 0;
        bus.data_addr      = 0;
        bus.data_wdata     = 0;
        bus.data_wstrb     = 0;
        bus.data_rready    = 0;
        bus.mem_req_ready  = 0;
        bus.mem_rvalid     = 0;
    endtask

    task automatic model_reset();
        prev_data = 1;
        m_i = 0;
        m_d = 0;
        m_c = 0;
    endtask

    task automatic chk_cnt();
        chk("inst_cnt", igc, m_i);
        chk("data_cnt", dgc, m_d);
        chk("conf_cnt", cc, m_c);
    endtask

    // dop: 0 none, 1 load, 2 store, 3 load+store (acts as store)
    task automatic txn(input bit ireq, input int dop, input int kst,
                       input int jst, input bit drop, input bit stray);
        logic [31:0] ia, da, dw, rd;
        logic [3:0]  ws;
        bit own_d, is_wr, d_rd, d_wr, lk, dr, lj;
        ia   = $urandom & 32'hFFFF_FFFC;
        da   = $urandom & 32'hFFFF_FFFC;
        dw   = $urandom;
        ws   = 4'($urandom);
        d_rd = (dop == 1) || (dop == 3);
        d_wr = (dop >= 2);
        bus.inst_req_valid = ireq;
        bus.inst_addr      = ia;
        bus.data_read      = d_rd;
        bus.data_write     = d_wr;
        bus.data_addr      = da;
        bus.data_wdata     = dw;
        bus.data_wstrb     = ws;
        bus.mem_req_ready  = 0;
        bus.mem_rvalid     = stray;
        bus.mem_rdata      = $urandom;
        bus.inst_ready     = 1'($urandom);
        bus.data_rready    = 1'($urandom);
        @(negedge clk);
        chk("idle_rd", bus.mem_read, 0);
        chk("idle_wr", bus.mem_write, 0);
        chk("idle_iv", bus.inst_valid, 0);
        chk("idle_dv", bus.data_rvalid, 0);
        chk("idle_rr", bus.mem_rready, 0);
        chk("idle_irdy", bus.inst_req_ready, 0);
        chk("idle_drdy", bus.data_req_ready, 0);
        if (!ireq && dop == 0) begin
            step();
            bus.mem_rvalid = 0;
            chk_cnt();
            return;
        end
        if (ireq && dop != 0) begin
            own_d = !prev_data;
            m_c++;
        end else begin
            own_d = (dop != 0);
        end
        prev_data = own_d;
        if (own_d) m_d++;
        else m_i++;
        is_wr = own_d && d_wr;
        step();
        for (int k = 0; k <= kst; k++) begin
            lk = (k == kst);
            dr = drop && (k == 0) && !lk;
            if (dr) begin
                if (own_d) begin
                    bus.data_read  = 0;
                    bus.data_write = 0;
                end else begin
                    bus.inst_req_valid = 0;
                end
            end
            bus.mem_req_ready = lk;
            bus.mem_rvalid    = 1'($urandom);
            @(negedge clk);
            chk("req_addr", bus.mem_addr, own_d ? da : ia);
            chk("req_rd", bus.mem_read,
                dr ? 0 : (own_d ? (d_rd && !d_wr) : 1));
            chk("req_wr", bus.mem_write, dr ? 0 : is_wr);
            chk("req_wstrb", bus.mem_wstrb, own_d ? ws : 4'h0);
            if (own_d) chk("req_wdata", bus.mem_wdata, dw);
            chk("req_irdy", bus.inst_req_ready, !own_d && lk);
            chk("req_drdy", bus.data_req_ready, own_d && lk);
            chk("req_rr", bus.mem_rready, 0);
            chk("req_iv", bus.inst_valid, 0);
            chk("req_dv", bus.data_rvalid, 0);
            step();
            bus.inst_req_valid = ireq;
            bus.data_read      = d_rd;
            bus.data_write     = d_wr;
        end
        bus.inst_req_valid = 0;
        bus.data_read      = 0;
        bus.data_write     = 0;
        bus.mem_req_ready  = 0;
        bus.mem_rvalid     = 0;
        if (!is_wr) begin
            for (int j = 0; j <= jst; j++) begin
                lj = (j == jst);
                rd = $urandom;
                bus.mem_rvalid = 1;
                bus.mem_rdata  = rd;
                if (own_d) begin
                    bus.data_rready = lj;
                    bus.inst_ready  = 1'($urandom);
                end else begin
                    bus.inst_ready  = lj;
                    bus.data_rready = 1'($urandom);
                end
                @(negedge clk);
                chk("rsp_iv", bus.inst_valid, !own_d);
                chk("rsp_dv", bus.data_rvalid, own_d);
                if (own_d) chk("rsp_drdata", bus.data_rdata, rd);
                else chk("rsp_irdata", bus.inst_rdata, rd);
                chk("rsp_rr", bus.mem_rready, lj);
                step();
            end
        end
        bus.mem_rvalid  = 0;
        bus.inst_ready  = 0;
        bus.data_rready = 0;
        chk_cnt();
    endtask

    initial begin
        rst = 0;
        quiet();
        bus.mem_rdata = 32'h5A5A_1234;
        model_reset();
        #2;
        chk("rst_rd", bus.mem_read, 0);
        chk("rst_wr", bus.mem_write, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_rr", bus.mem_rready, 0);
        chk("rst_iv", bus.inst_valid, 0);
        chk("rst_irdata", bus.inst_rdata, 32'h5A5A_1234);
        chk("rst_drdata", bus.data_rdata, 32'h5A5A_1234);
        chk_cnt();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;

        txn(1, 1, 0, 0, 0, 0);
        txn(1, 1, 1, 1, 0, 0);
        txn(1, 1, 0, 0, 0, 0);
        txn(0, 1, 5, 3, 0, 0);
        txn(0, 2, 0, 0, 0, 0);
        txn(0, 3, 2, 0, 1, 0);
        txn(0, 0, 0, 0, 0, 1);
        txn(1, 0, 3, 2, 1, 1);

        repeat (300)
            txn(1'($urandom), $urandom_range(0, 3), $urandom_range(0, 5),
                $urandom_range(0, 3), 1'($urandom), 1'($urandom));

        bus.inst_req_valid = 1;
        bus.inst_addr      = 32'h100;
        step();
        m_i++;
        prev_data = 0;
        bus.mem_req_ready = 1;
        step();
        bus.mem_req_ready  = 0;
        bus.inst_req_valid = 0;
        bus.mem_rvalid     = 1;
        bus.mem_rdata      = 32'h2402_0005;
        bus.inst_ready     = 0;
        @(negedge clk);
        chk("ar_iv_pre", bus.inst_valid, 1);
        chk("ar_rdata", bus.inst_rdata, 32'h2402_0005);
        chk("ar_icnt_pre", igc, m_i);
        #1 rst = 0;
        #1;
        chk("ar_iv", bus.inst_valid, 0);
        chk("ar_rr", bus.mem_rready, 0);
        chk("ar_rd", bus.mem_read, 0);
        model_reset();
        chk_cnt();
        step();
        step();
        rst = 1;
        bus.mem_rvalid = 0;
        txn(1, 1, 0, 0, 0, 0);
        txn(1, 2, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
